// File: rtl/inst_mem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter.
// This file holds the bus width, the zero word, the default memory depth,
// the stall levels and the arbiter state encoding.
package inst_mem_arbiter_pkg;

  localparam int          InstBus        = 32;
  localparam logic [31:0] ZeroWord       = 32'h0000_0000;
  localparam int          InstMemNumLog2 = 10;

  localparam logic StallAssert   = 1'b1;
  localparam logic StallDeassert = 1'b0;

  // BOOT: the loader owns the memory. RUN: fetch has priority and the
  // loader is protected against starvation.
  typedef enum logic {
    ArbBoot = 1'b0,
    ArbRun  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/inst_mem_arbiter.sv
// Arbiter for the single-port instruction RAM.
// The RAM is shared by the CPU fetch stage and the program loader/debug port.
// Grants are combinational, so mem_* is driven in the same cycle as the grant.
// Responses appear one cycle later and are valid together with the RAM read data.
module inst_mem_arbiter
  import inst_mem_arbiter_pkg::*;
#(
  parameter int AW         = InstMemNumLog2,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [InstBus-1:0] if_addr,
  output logic [InstBus-1:0] if_inst,
  output logic               if_valid,
  output logic               if_stall,
  input  logic               ld_req,
  input  logic               ld_we,
  input  logic [InstBus-1:0] ld_addr,
  input  logic [InstBus-1:0] ld_wdata,
  output logic [InstBus-1:0] ld_rdata,
  output logic               ld_ack,
  input  logic               ld_done,
  output logic               mem_ce,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [InstBus-1:0] mem_wdata,
  input  logic [InstBus-1:0] mem_rdata
);

  arb_state_e        state_reg;
  logic [3:0]        wait_cnt_reg;
  logic              if_valid_reg;
  logic              ld_ack_reg;
  logic              ld_rd_reg;
  logic [InstBus-1:0] if_inst_hold_reg;
  logic [InstBus-1:0] ld_rdata_hold_reg;

  logic              ld_pend;
  logic              starved;
  logic              if_grant;
  logic              ld_grant;
  logic [InstBus-1:0] sel_addr;
  logic              unused_addr_bits;

  // A request whose ack is showing this cycle has already been served.
  assign ld_pend = ld_req & ~ld_ack_reg;
  assign starved = (wait_cnt_reg == 4'(STARVE_MAX));

  // Decide who owns the RAM this cycle. While reset is held nobody does.
  always_comb begin
    if_grant = 1'b0;
    ld_grant = 1'b0;
    if_stall = StallAssert;
    if (rst) begin
      if (state_reg == ArbBoot) begin
        ld_grant = ld_pend;
      end else begin
        if (if_req && !(ld_pend && starved)) begin
          if_grant = 1'b1;
        end else if (ld_pend) begin
          ld_grant = 1'b1;
        end
        if_stall = (if_req && !if_grant) ? StallAssert : StallDeassert;
      end
    end
  end

  // Drive the RAM from the winner. Idle cycles park the bus at zero.
  always_comb begin
    sel_addr  = ld_grant ? ld_addr : if_addr;
    mem_ce    = if_grant | ld_grant;
    mem_we    = ld_grant & ld_we;
    mem_addr  = mem_ce ? sel_addr[AW+1:2] : '0;
    mem_wdata = (ld_grant && ld_we) ? ld_wdata : ZeroWord;
  end

  // Byte-offset and wrap-around address bits are intentionally dropped.
  assign unused_addr_bits = ^{sel_addr[InstBus-1:AW+2], sel_addr[1:0]};

  // Boot/run sequencing, the starvation counter, and the response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= ArbBoot;
      wait_cnt_reg      <= 4'd0;
      if_valid_reg      <= 1'b0;
      ld_ack_reg        <= 1'b0;
      ld_rd_reg         <= 1'b0;
      if_inst_hold_reg  <= ZeroWord;
      ld_rdata_hold_reg <= ZeroWord;
    end else begin
      if (state_reg == ArbBoot) begin
        if (ld_done && !ld_grant) state_reg <= ArbRun;
        wait_cnt_reg <= 4'd0;
      end else if (ld_grant || !ld_pend) begin
        wait_cnt_reg <= 4'd0;
      end else begin
        // A loader request is pending but fetch won the cycle.
        wait_cnt_reg <= wait_cnt_reg + 4'd1;
      end
      if_valid_reg <= if_grant;
      ld_ack_reg   <= ld_grant;
      ld_rd_reg    <= ld_grant & ~ld_we;
      if (if_valid_reg)           if_inst_hold_reg  <= mem_rdata;
      if (ld_ack_reg && ld_rd_reg) ld_rdata_hold_reg <= mem_rdata;
    end
  end

  // RAM data arrives one cycle after the grant, so pass it straight through.
  // Otherwise hold the last value.
  assign if_valid = if_valid_reg;
  assign if_inst  = if_valid_reg ? mem_rdata : if_inst_hold_reg;
  assign ld_ack   = ld_ack_reg;
  assign ld_rdata = (ld_ack_reg && ld_rd_reg) ? mem_rdata : ld_rdata_hold_reg;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Testbench for inst_mem_arbiter.
// The bench has a synchronous RAM, a loader agent, and a reference model
// written in terms of "who owns this cycle".
module tb_inst_mem_arbiter;

  localparam int AW     = 10;
  localparam int STARVE = 4;
  localparam int DEPTH  = 1 << AW;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, ld_req = 1'b0, ld_we = 1'b0, ld_done = 1'b0;
  logic [31:0] if_addr = '0, ld_addr = '0, ld_wdata = '0;
  logic [31:0] if_inst, ld_rdata, mem_wdata, mem_rdata;
  logic        if_valid, if_stall, ld_ack, mem_ce, mem_we;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  inst_mem_arbiter #(.AW(AW), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_valid(if_valid), .if_stall(if_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack), .ld_done(ld_done),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Single-port synchronous instruction RAM
  logic [31:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_run, m_ack, m_rd, m_valid, m_inst_known, m_rdata_known;
  int          m_blocked;
  logic [31:0] m_inst, m_rdata;
  logic [31:0] ref_mem   [0:DEPTH-1];
  bit          ref_known [0:DEPTH-1];

  bit          obs_ack, obs_stall, obs_valid;
  logic [31:0] obs_inst, obs_rdata;

  task automatic model_reset();
    m_run = 0; m_ack = 0; m_rd = 0; m_valid = 0; m_blocked = 0;
    m_inst = '0; m_rdata = '0; m_inst_known = 1; m_rdata_known = 1;
  endtask

  // One clock cycle: drive inputs, check at the falling edge, then advance the model.
  task automatic step(input bit fr, input logic [31:0] fa, input bit lr, input bit lw,
                      input logic [31:0] la, input logic [31:0] lwd, input bit done);
    int          who;   // 0 idle, 1 fetch, 2 loader
    bit          wants;
    int          idx;
    logic [31:0] sel;
    if_req = fr; if_addr = fa; ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = lwd; ld_done = done;
    @(negedge clk);
    wants = lr && !m_ack;
    if (!m_run)                                  who = wants ? 2 : 0;
    else if (fr && !(wants && m_blocked == STARVE)) who = 1;
    else if (wants)                              who = 2;
    else                                         who = 0;
    sel = (who == 2) ? la : fa;
    idx = int'(sel[AW+1:2]);
    chk("mem_ce", 32'(mem_ce), 32'(who != 0));
    chk("mem_we", 32'(mem_we), 32'(who == 2 && lw));
    if (who != 0)        chk("mem_addr", 32'(mem_addr), 32'(idx));
    if (who == 2 && lw)  chk("mem_wdata", mem_wdata, lwd);
    chk("if_valid", 32'(if_valid), 32'(m_valid));
    if (m_inst_known)    chk("if_inst", if_inst, m_inst);
    chk("ld_ack", 32'(ld_ack), 32'(m_ack));
    if (m_ack && m_rd && m_rdata_known) chk("ld_rdata", ld_rdata, m_rdata);
    if (!m_run || fr)    chk("if_stall", 32'(if_stall), 32'(!m_run || who != 1));
    obs_ack = ld_ack; obs_stall = if_stall; obs_valid = if_valid;
    obs_inst = if_inst; obs_rdata = ld_rdata;
    // advance the model by one cycle
    m_valid = (who == 1);
    if (who == 1) begin m_inst = ref_mem[idx]; m_inst_known = ref_known[idx]; end
    m_ack = (who == 2);
    m_rd  = (who == 2) && !lw;
    if (who == 2) begin
      if (lw) begin ref_mem[idx] = lwd; ref_known[idx] = 1; end
      else begin m_rdata = ref_mem[idx]; m_rdata_known = ref_known[idx]; end
    end
    if (m_run && wants && who == 1) m_blocked++;
    else                            m_blocked = 0;
    if (!m_run && done && who != 2) m_run = 1;
    @(posedge clk); #1;
  endtask

  // Hold one loader request until it is acked. The wait is bounded.
  task automatic ld_xfer(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input bit fr, input logic [31:0] fa, output int lat);
    bit got = 0;
    lat = 0;
    while (!got && lat < 20) begin
      step(fr, fa, 1, we, a, d, 0);
      lat++;
      if (obs_ack) got = 1;
    end
    if (!got) chk("ld_ack_timeout", 32'(0), 32'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_if_inst"}, if_inst, 32'h0);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'h0);
    chk({tag, "_if_stall"}, 32'(if_stall), 32'h1);
    chk({tag, "_ld_rdata"}, ld_rdata, 32'h0);
    chk({tag, "_ld_ack"}, 32'(ld_ack), 32'h0);
    chk({tag, "_mem_ce"}, 32'(mem_ce), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  task automatic do_reset();
    rst = 0; if_req = 0; ld_req = 0; ld_done = 0;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 rst = 1;
    model_reset();
  endtask

  int lat, stall_at;
  logic [31:0] tmp;
  bit la_active, la_we;
  logic [31:0] la_addr, la_wdata;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; ref_known[i] = 0; end
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    rst = 1;

    // Boot: fetch is stalled and the RAM stays idle.
    for (int i = 0; i < 10; i++) step(1, 32'h0, 0, 0, 0, 0, 0);
    chk("boot_hold_stall", 32'(obs_stall), 32'h1);

    // Boot loads, then a read-back.
    ld_xfer(1, 32'h0, 32'h2401_0005, 0, 0, lat); chk("ld_w0_lat", 32'(lat), 32'd2);
    ld_xfer(1, 32'h4, 32'h2402_0007, 0, 0, lat); chk("ld_w1_lat", 32'(lat), 32'd2);
    ld_xfer(0, 32'h4, 32'h0, 1, 0, lat);         chk("ld_r1_lat", 32'(lat), 32'd2);
    chk("boot_rdata", obs_rdata, 32'h2402_0007);

    // Enter run mode, then fetch two words back to back.
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 32'h0, 0, 0, 0, 0, 0);  chk("run_stall0", 32'(obs_stall), 32'h0);
    step(1, 32'h4, 0, 0, 0, 0, 0);  chk("fetch0", obs_inst, 32'h2401_0005);
    step(0, 32'h0, 0, 0, 0, 0, 0);  chk("fetch1", obs_inst, 32'h2402_0007);

    // Starvation: the loader is forced through on the fifth blocked cycle.
    stall_at = 0;
    for (int i = 1; i <= 8 && stall_at == 0; i++) begin
      step(1, 32'h4, 1, 0, 32'h0, 0, 0);
      if (obs_stall) stall_at = i;
    end
    chk("starve_cycle", 32'(stall_at), 32'd5);
    step(1, 32'h4, 1, 0, 32'h0, 0, 0);
    chk("starve_ack", 32'(obs_ack), 32'h1);
    chk("starve_rdata", obs_rdata, 32'h2401_0005);
    chk("starve_one_stall", 32'(obs_stall), 32'h0);

    // Reset during a live loader grant: no ack, and everything returns to its reset value.
    if_req = 0; ld_req = 1; ld_we = 1; ld_addr = 32'hC; ld_wdata = 32'hDEAD_BEEF;
    #1 chk("abort_grant_live", 32'(mem_ce), 32'h1);
    rst = 0;
    #1 check_reset_outputs("abort");
    do_reset();
    step(1, 32'h0, 0, 0, 0, 0, 0); chk("abort_no_ack", 32'(obs_ack), 32'h0);
    chk("abort_boot", 32'(obs_stall), 32'h1);

    // ld_done in the same cycle as a loader grant delays the exit by one cycle.
    step(0, 0, 1, 1, 32'h8, 32'hCAFE_F00D, 1);
    step(1, 32'h8, 1, 1, 32'h8, 32'hCAFE_F00D, 1);
    chk("done_ack", 32'(obs_ack), 32'h1);
    chk("done_still_boot", 32'(obs_stall), 32'h1);
    step(1, 32'h8, 0, 0, 0, 0, 0);  chk("done_run", 32'(obs_stall), 32'h0);
    step(1, 32'hC, 0, 0, 0, 0, 0);  chk("done_fetch", obs_inst, 32'hCAFE_F00D);

    // Random traffic from reset. Boot exit is random, addresses wrap, and the loader follows the handshake.
    do_reset();
    la_active = 0; la_we = 0; la_addr = '0; la_wdata = '0;
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] fa;
      if (!la_active && $urandom_range(0, 2) == 0) begin
        la_active = 1;
        la_we     = ($urandom_range(0, 1) == 1);
        tmp       = $urandom;
        la_addr   = {tmp[31:12], 7'b0, 3'($urandom_range(0, 7)), tmp[1:0]};
        la_wdata  = $urandom;
      end
      tmp = $urandom;
      fa  = {tmp[31:12], 7'b0, 3'($urandom_range(0, 7)), tmp[1:0]};
      step(($urandom_range(0, 3) != 0), fa, la_active, la_we, la_addr, la_wdata,
           ($urandom_range(0, 29) == 0));
      if (obs_ack) la_active = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
